output_arbiter_ravenoc: RTL and testbench

Wormhole round-robin arbiter that shares one router output port between the four input modules that can target it. It picks a requester that is presenting a head flit, locks the output to it until that requester's tail flit is accepted, and then releases the port with round-robin fairness. It sits between the routing-decision crossbar mapping and each output module's flit buffer.

---
 rtl/output_arbiter_ravenoc_if.sv | 28 ++
 rtl/output_arbiter_ravenoc.sv | 105 ++++++++++
 tb/tb_output_arbiter_ravenoc.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_arbiter_ravenoc_if.sv
// Requester/output handshake bundle for the wormhole output arbiter.
// master = requester/output-module side, slave = arbiter side.
interface output_arbiter_ravenoc_if #(
   parameter int unsigned REQ_NUM    = 4,
   parameter int unsigned FLIT_WIDTH = 34
);
   logic [REQ_NUM-1:0]            req_valid_i;
   logic [REQ_NUM-1:0]            req_head_i;
   logic [REQ_NUM-1:0]            req_tail_i;
   logic [REQ_NUM*FLIT_WIDTH-1:0] req_flit_i;
   logic [REQ_NUM-1:0]            req_ready_o;
   logic                          out_valid_o;
   logic [FLIT_WIDTH-1:0]         out_flit_o;
   logic                          out_ready_i;
   logic [REQ_NUM-1:0]            grant_o;
   logic                          busy_o;
   logic [15:0]                   pkt_cnt_o;

   modport master (
      output req_valid_i, req_head_i, req_tail_i, req_flit_i, out_ready_i,
      input  req_ready_o, out_valid_o, out_flit_o, grant_o, busy_o, pkt_cnt_o
   );

   modport slave (
      input  req_valid_i, req_head_i, req_tail_i, req_flit_i, out_ready_i,
      output req_ready_o, out_valid_o, out_flit_o, grant_o, busy_o, pkt_cnt_o
   );
endinterface

// File: rtl/output_arbiter_ravenoc.sv
// Wormhole round-robin arbiter: locks one output port to a requester from
// its head flit until its tail flit is accepted.
module output_arbiter_ravenoc #(
   parameter int unsigned REQ_NUM    = 4,
   parameter int unsigned FLIT_WIDTH = 34
) (
   input logic                     clk,
   input logic                     arst,
   output_arbiter_ravenoc_if.slave bus
);
   localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [REQ_NUM-1:0]    grant_q, grant_d;
   logic [PTR_W-1:0]      owner_q, owner_d;
   logic [PTR_W-1:0]      last_ptr_q, last_ptr_d;
   logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
   logic [REQ_NUM-1:0]    eligible;
   logic [PTR_W-1:0]      cand;
   logic                  found;
   logic                  owner_valid;
   logic                  owner_tail;
   logic [FLIT_WIDTH-1:0] owner_flit;
   logic                  xfer;

   assign eligible = bus.req_valid_i & bus.req_head_i;

   // Owner's request signals; all zero while no grant is held.
   always_comb begin
      owner_valid = 1'b0;
      owner_tail  = 1'b0;
      owner_flit  = '0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (grant_q[i]) begin
            owner_valid = bus.req_valid_i[i];
            owner_tail  = bus.req_tail_i[i];
            owner_flit  = bus.req_flit_i[i*FLIT_WIDTH +: FLIT_WIDTH];
         end
      end
   end

   assign xfer = owner_valid & bus.out_ready_i;

   // Next-state: rotating-priority pick in IDLE, release on owner's tail.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      last_ptr_d = last_ptr_q;
      pkt_cnt_d  = pkt_cnt_q;
      cand       = '0;
      found      = 1'b0;
      unique case (state_q)
         IDLE: begin
            for (int unsigned k = 1; k <= REQ_NUM; k++) begin
               cand = PTR_W'((32'(last_ptr_q) + k) % REQ_NUM);
               if (!found && eligible[cand]) begin
                  found   = 1'b1;
                  owner_d = cand;
               end
            end
            if (found) begin
               state_d          = LOCKED;
               grant_d          = '0;
               grant_d[owner_d] = 1'b1;
            end
         end
         LOCKED: begin
            if (xfer && owner_tail) begin
               state_d    = IDLE;
               grant_d    = '0;
               last_ptr_d = owner_q;
               pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         last_ptr_q <= PTR_W'(REQ_NUM - 1);
         pkt_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         last_ptr_q <= last_ptr_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   assign bus.grant_o     = grant_q;
   assign bus.busy_o      = (state_q == LOCKED);
   assign bus.pkt_cnt_o   = pkt_cnt_q;
   assign bus.out_valid_o = owner_valid;
   assign bus.out_flit_o  = owner_flit;
   assign bus.req_ready_o = grant_q & {REQ_NUM{bus.out_ready_i}};
endmodule

// File: tb/tb_output_arbiter_ravenoc.sv
// Directed bench for output_arbiter_ravenoc: per-requester flit queues drive
// the DUT, and an expected-transfer queue is checked on every accepted flit.
module tb_output_arbiter_ravenoc;
   localparam int unsigned RN = 4;
   localparam int unsigned FW = 34;

   typedef struct packed {
      logic          head;
      logic          tail;
      logic [FW-1:0] data;
   } flit_t;

   typedef struct packed {
      logic [1:0]    req;
      logic [FW-1:0] data;
   } exp_t;

   logic clk;
   logic arst;

   output_arbiter_ravenoc_if #(.REQ_NUM(RN), .FLIT_WIDTH(FW)) bus ();

   output_arbiter_ravenoc #(.REQ_NUM(RN), .FLIT_WIDTH(FW)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   flit_t         rq [RN][$];
   exp_t          exp_q [$];
   logic [RN-1:0] acc;
   int            n_chk;
   int            n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      flit_t f;
      for (int i = 0; i < int'(RN); i++) begin
         if (rq[i].size() != 0) begin
            f = rq[i][0];
            bus.req_valid_i[i]           = 1'b1;
            bus.req_head_i[i]            = f.head;
            bus.req_tail_i[i]            = f.tail;
            bus.req_flit_i[i*FW +: FW]   = f.data;
         end else begin
            bus.req_valid_i[i]           = 1'b0;
            bus.req_head_i[i]            = 1'b0;
            bus.req_tail_i[i]            = 1'b0;
            bus.req_flit_i[i*FW +: FW]   = '0;
         end
      end
   endtask

   // One clock: scoreboard at negedge, pop accepted flits after posedge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      acc = bus.req_valid_i & bus.req_ready_o;
      if (bus.out_valid_o && bus.out_ready_i) begin
         check_eq("sb_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("sb_flit", 64'(bus.out_flit_o), 64'(e.data));
            check_eq("sb_owner", 64'(bus.grant_o), 64'(RN'(1) << e.req));
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(RN); i++)
         if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      drive();
      #1;
   endtask

   task automatic push_pkt(input int r, input int n, input logic [FW-1:0] base);
      flit_t f;
      exp_t  e;
      for (int k = 0; k < n; k++) begin
         f.head = (k == 0);
         f.tail = (k == n - 1);
         f.data = base + FW'(k);
         rq[r].push_back(f);
         e.req  = 2'(r);
         e.data = f.data;
         exp_q.push_back(e);
      end
   endtask

   task automatic flush();
      for (int i = 0; i < int'(RN); i++) rq[i].delete();
      exp_q.delete();
      drive();
   endtask

   task automatic do_reset();
      flush();
      arst = 1'b0;
      tick();
      arst = 1'b1;
   endtask

   int ord [5] = '{0, 1, 2, 3, 0};

   initial begin
      flit_t body;
      n_chk           = 0;
      n_fail          = 0;
      acc             = '0;
      arst            = 1'b0;
      bus.out_ready_i = 1'b1;
      flush();

      // Reset values
      tick();
      tick();
      check_eq("rst_grant", 64'(bus.grant_o), 64'd0);
      check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
      check_eq("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      check_eq("rst_out_flit", 64'(bus.out_flit_o), 64'd0);
      check_eq("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
      check_eq("rst_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd0);
      arst = 1'b1;

      // 3-flit packet from req 2
      push_pkt(2, 3, FW'(1));
      drive();
      tick();
      check_eq("t1_grant", 64'(bus.grant_o), 64'h4);
      check_eq("t1_busy", 64'(bus.busy_o), 64'd1);
      check_eq("t1_flit0", 64'(bus.out_flit_o), 64'h1);
      check_eq("t1_ready", 64'(bus.req_ready_o), 64'h4);
      tick();
      check_eq("t1_flit1", 64'(bus.out_flit_o), 64'h2);
      tick();
      check_eq("t1_flit2", 64'(bus.out_flit_o), 64'h3);
      tick();
      check_eq("t1_busy_fall", 64'(bus.busy_o), 64'd0);
      check_eq("t1_grant_clr", 64'(bus.grant_o), 64'd0);
      check_eq("t1_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd1);
      check_eq("t1_drained", 64'(exp_q.size()), 64'd0);

      // Four single-flit requesters, round-robin with one bubble
      do_reset();
      for (int p = 0; p < 5; p++) push_pkt(ord[p], 1, FW'(32'h100 + p));
      drive();
      for (int p = 0; p < 5; p++) begin
         tick();
         check_eq("t2_grant", 64'(bus.grant_o), 64'(RN'(1) << ord[p]));
         tick();
         check_eq("t2_bubble", 64'(bus.grant_o), 64'd0);
      end
      check_eq("t2_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd5);
      check_eq("t2_drained", 64'(exp_q.size()), 64'd0);

      // Head from req 0 while req 1 holds the lock
      do_reset();
      push_pkt(1, 4, FW'(32'h10));
      drive();
      tick();
      check_eq("t3_grant1", 64'(bus.grant_o), 64'h2);
      tick();
      push_pkt(0, 1, FW'(32'h20));
      drive();
      #1;
      for (int c = 0; c < 3; c++) begin
         check_eq("t3_ready0_low", 64'(bus.req_ready_o[0]), 64'd0);
         check_eq("t3_hold", 64'(bus.grant_o), 64'h2);
         tick();
      end
      check_eq("t3_idle_bubble", 64'(bus.grant_o), 64'd0);
      check_eq("t3_ready0_bubble", 64'(bus.req_ready_o[0]), 64'd0);
      tick();
      check_eq("t3_grant0", 64'(bus.grant_o), 64'h1);
      tick();
      check_eq("t3_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd2);
      check_eq("t3_drained", 64'(exp_q.size()), 64'd0);

      // Toggling out_ready during a 4-flit packet from req 3
      do_reset();
      push_pkt(3, 4, FW'(32'h30));
      drive();
      tick();
      check_eq("t4_grant", 64'(bus.grant_o), 64'h8);
      for (int c = 0; c < 8; c++) begin
         bus.out_ready_i = (c % 2 == 0);
         tick();
         check_eq("t4_busy", 64'(bus.busy_o), 64'(c < 6));
      end
      bus.out_ready_i = 1'b1;
      check_eq("t4_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd1);
      check_eq("t4_drained", 64'(exp_q.size()), 64'd0);

      // Body flit while IDLE is never granted nor accepted
      do_reset();
      body.head = 1'b0;
      body.tail = 1'b0;
      body.data = FW'(32'h55);
      rq[1].push_back(body);
      drive();
      for (int c = 0; c < 10; c++) begin
         tick();
         check_eq("t5_grant", 64'(bus.grant_o), 64'd0);
         check_eq("t5_ready", 64'(bus.req_ready_o), 64'd0);
         check_eq("t5_valid", 64'(bus.out_valid_o), 64'd0);
      end
      flush();

      // Reset mid-packet restores the pointer and abandons the packet
      do_reset();
      push_pkt(0, 1, FW'(32'h3F));
      drive();
      tick();
      tick();
      check_eq("t6_pre_cnt", 64'(bus.pkt_cnt_o), 64'd1);
      push_pkt(2, 3, FW'(32'h40));
      drive();
      tick();
      check_eq("t6_grant2", 64'(bus.grant_o), 64'h4);
      tick();
      check_eq("t6_second", 64'(bus.out_flit_o), 64'h41);
      arst = 1'b0;
      tick();
      arst = 1'b1;
      flush();
      check_eq("t6_grant_rst", 64'(bus.grant_o), 64'd0);
      check_eq("t6_busy_rst", 64'(bus.busy_o), 64'd0);
      check_eq("t6_cnt_rst", 64'(bus.pkt_cnt_o), 64'd0);
      push_pkt(0, 1, FW'(32'h60));
      push_pkt(3, 1, FW'(32'h50));
      drive();
      tick();
      check_eq("t6_ptr_grant0", 64'(bus.grant_o), 64'h1);
      tick();
      tick();
      check_eq("t6_grant3", 64'(bus.grant_o), 64'h8);
      tick();
      check_eq("t6_drained", 64'(exp_q.size()), 64'd0);

      // Packet counter wraps
      do_reset();
      force dut.pkt_cnt_q = 16'hFFFF;
      #1;
      release dut.pkt_cnt_q;
      check_eq("t7_cnt_max", 64'(bus.pkt_cnt_o), 64'hFFFF);
      push_pkt(1, 1, FW'(32'h70));
      drive();
      tick();
      tick();
      check_eq("t7_cnt_wrap", 64'(bus.pkt_cnt_o), 64'h0);
      check_eq("t7_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
